// File: rtl/adc_if_pkg.sv
// Shared types and constants for the parallel ADC interface.
package adc_if_pkg;

    typedef logic [15:0] adc_word_t;

    localparam int unsigned NUM_CH_DEFAULT = 8;

    // Value driven onto the bus when no valid channel word is available
    localparam adc_word_t ADC_IDLE_WORD = 16'h0000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONVERTING = 2'd1,
        READY      = 2'd2
    } adc_resp_state_e;

endpackage

// File: rtl/edge_detect.sv
// Registers a level input and flags its rising/falling transitions.
module edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic sreset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    // Previous-cycle copy of the input
    always_ff @(posedge clk) begin
        if (sreset) begin
            d_q <= RESET_VAL;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/adc_responder.sv
// ADC stand-in: BUSY pulse per conversion, channel readout, config latch.
module adc_responder
    import adc_if_pkg::*;
#(
    parameter int unsigned CONV_CYCLES = 25,
    parameter int unsigned NUM_CH      = NUM_CH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 sreset,
    input  logic                 chipselect_n,
    input  logic                 read_n,
    input  logic                 write_n,
    input  logic                 software_mode,
    input  logic                 standby_n,
    input  logic                 conv_start_a,
    input  logic                 conv_start_b,
    input  logic                 conv_start_c,
    input  logic                 conv_start_d,
    input  logic [16*NUM_CH-1:0] sample_in,
    input  logic [15:0]          db_in,
    output logic                 busy,
    output logic [15:0]          db_out,
    output logic                 db_oe,
    output logic [7:0]           cfg_out,
    output logic                 rd_err
);

    localparam int unsigned CNT_W = $clog2(CONV_CYCLES);
    localparam int unsigned IDX_W = $clog2(NUM_CH);
    // One extra count so the pointer can sit at "frame exhausted"
    localparam int unsigned PTR_W = $clog2(NUM_CH + 1);
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(NUM_CH);

    adc_resp_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q;
    adc_word_t [NUM_CH-1:0] shadow_q;
    adc_word_t [NUM_CH-1:0] result_q;
    adc_word_t db_out_q;
    logic db_oe_q;
    logic [7:0] cfg_q;
    logic rd_err_q;
    logic load_shadow;
    logic commit;

    logic start_all;
    logic start_rise, start_fall;
    logic read_rise, read_fall;
    logic write_rise, write_fall;
    logic rd_accept;
    logic unused_edges;

    assign start_all = conv_start_a & conv_start_b & conv_start_c & conv_start_d;

    edge_detect #(.RESET_VAL(1'b0)) u_start_edge (
        .clk    (clk),
        .sreset (sreset),
        .d      (start_all),
        .rise   (start_rise),
        .fall   (start_fall)
    );

    edge_detect #(.RESET_VAL(1'b1)) u_read_edge (
        .clk    (clk),
        .sreset (sreset),
        .d      (read_n),
        .rise   (read_rise),
        .fall   (read_fall)
    );

    edge_detect #(.RESET_VAL(1'b1)) u_write_edge (
        .clk    (clk),
        .sreset (sreset),
        .d      (write_n),
        .rise   (write_rise),
        .fall   (write_fall)
    );

    assign unused_edges = start_fall ^ read_rise ^ write_fall;
    assign rd_accept    = read_fall & ~chipselect_n;

    // Next-state: standby overrides everything, start edges only outside CONVERTING
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_shadow = 1'b0;
        commit      = 1'b0;
        if (!standby_n) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, READY: begin
                    if (start_rise) begin
                        state_d     = CONVERTING;
                        cnt_d       = CNT_W'(CONV_CYCLES - 1);
                        load_shadow = 1'b1;
                    end
                end
                CONVERTING: begin
                    if (cnt_q == '0) begin
                        state_d = READY;
                        commit  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and conversion counter
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sample capture, readout pointer, bus data and error flag
    always_ff @(posedge clk) begin
        if (sreset) begin
            shadow_q <= '0;
            result_q <= '0;
            ptr_q    <= '0;
            db_out_q <= ADC_IDLE_WORD;
            db_oe_q  <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            db_oe_q <= ~chipselect_n & ~read_n;
            if (load_shadow) begin
                shadow_q <= sample_in;
                rd_err_q <= 1'b0;
            end
            if (commit) begin
                result_q <= shadow_q;
                ptr_q    <= '0;
            end
            if (rd_accept) begin
                unique case (state_q)
                    READY: begin
                        if (ptr_q < PTR_END) begin
                            db_out_q <= result_q[ptr_q[IDX_W-1:0]];
                            ptr_q    <= ptr_q + 1'b1;
                        end else begin
                            db_out_q <= ADC_IDLE_WORD;
                            rd_err_q <= 1'b1;
                        end
                    end
                    CONVERTING: begin
                        db_out_q <= ADC_IDLE_WORD;
                        rd_err_q <= 1'b1;
                    end
                    default: db_out_q <= ADC_IDLE_WORD;
                endcase
            end
        end
    end

    // Config latch; a write overlapping an active read is dropped
    always_ff @(posedge clk) begin
        if (sreset) begin
            cfg_q <= '0;
        end else if (write_rise && !chipselect_n && software_mode && read_n) begin
            cfg_q <= db_in[7:0];
        end
    end

    assign busy    = (state_q == CONVERTING);
    assign db_out  = db_out_q;
    assign db_oe   = db_oe_q;
    assign cfg_out = cfg_q;
    assign rd_err  = rd_err_q;

endmodule

// File: tb/tb_adc_responder.sv
// Directed self-checking bench for adc_responder.
module tb_adc_responder;

    localparam int unsigned NCH = 8;

    logic clk = 1'b0;
    logic sreset;
    logic chipselect_n, read_n, write_n;
    logic software_mode, standby_n;
    logic conv_start_a, conv_start_b, conv_start_c, conv_start_d;
    logic [16*NCH-1:0] sample_in;
    logic [15:0] db_in;
    logic busy;
    logic [15:0] db_out;
    logic db_oe;
    logic [7:0] cfg_out;
    logic rd_err;

    int total = 0;
    int bad   = 0;

    adc_responder #(.CONV_CYCLES(25), .NUM_CH(NCH)) dut (
        .clk           (clk),
        .sreset        (sreset),
        .chipselect_n  (chipselect_n),
        .read_n        (read_n),
        .write_n       (write_n),
        .software_mode (software_mode),
        .standby_n     (standby_n),
        .conv_start_a  (conv_start_a),
        .conv_start_b  (conv_start_b),
        .conv_start_c  (conv_start_c),
        .conv_start_d  (conv_start_d),
        .sample_in     (sample_in),
        .db_in         (db_in),
        .busy          (busy),
        .db_out        (db_out),
        .db_oe         (db_oe),
        .cfg_out       (cfg_out),
        .rd_err        (rd_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conv_all(input logic v);
        conv_start_a = v;
        conv_start_b = v;
        conv_start_c = v;
        conv_start_d = v;
    endtask

    task automatic load_samples(input logic [15:0] base);
        for (int k = 0; k < NCH; k++) begin
            sample_in[16*k +: 16] = base + 16'(k);
        end
    endtask

    // Start a conversion and count the cycles busy stays high (bounded)
    task automatic run_conv(output int n);
        conv_all(1'b1);
        tick();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 2) conv_all(1'b0);
            if (!busy) break;
            n++;
            tick();
        end
        conv_all(1'b0);
    endtask

    // One read strobe; returns bus data and drive enable seen while read_n is low
    task automatic do_read(output logic [15:0] d, output logic oe);
        chipselect_n = 1'b0;
        tick();
        read_n = 1'b0;
        tick();
        tick();
        d  = db_out;
        oe = db_oe;
        read_n = 1'b1;
        tick();
        tick();
        chipselect_n = 1'b1;
    endtask

    task automatic do_write(input logic [15:0] v);
        chipselect_n = 1'b0;
        db_in = v;
        write_n = 1'b0;
        tick();
        tick();
        write_n = 1'b1;
        tick();
        tick();
        chipselect_n = 1'b1;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100 && busy; i++) tick();
        check_eq("busy_wait_bound", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        logic oe;
        int n;

        sreset = 1'b1;
        chipselect_n = 1'b1;
        read_n = 1'b1;
        write_n = 1'b1;
        software_mode = 1'b0;
        standby_n = 1'b1;
        conv_all(1'b0);
        sample_in = '0;
        db_in = '0;
        repeat (3) tick();
        sreset = 1'b0;
        tick();

        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_db_out", 32'(db_out), 32'h0);
        check_eq("rst_db_oe", 32'(db_oe), 32'd0);
        check_eq("rst_cfg", 32'(cfg_out), 32'h0);
        check_eq("rst_rd_err", 32'(rd_err), 32'd0);

        // Read before any conversion: idle word, no error
        do_read(d, oe);
        check_eq("idle_read_data", 32'(d), 32'h0);
        check_eq("idle_read_err", 32'(rd_err), 32'd0);

        // First conversion: busy exactly 25 cycles
        load_samples(16'h1000);
        run_conv(n);
        check_eq("busy_len", 32'(n), 32'd25);

        for (int k = 0; k < NCH; k++) begin
            do_read(d, oe);
            check_eq($sformatf("read_ch%0d", k), 32'(d), 32'h1000 + 32'(k));
            check_eq($sformatf("read_oe%0d", k), 32'(oe), 32'd1);
        end
        check_eq("oe_drop", 32'(db_oe), 32'd0);
        check_eq("frame_no_err", 32'(rd_err), 32'd0);

        do_read(d, oe);
        check_eq("overrun_data", 32'(d), 32'h0);
        check_eq("overrun_err", 32'(rd_err), 32'd1);

        // Next start clears the error; read during busy errors
        load_samples(16'h2000);
        conv_all(1'b1);
        tick();
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_clears_err", 32'(rd_err), 32'd0);
        tick();
        conv_all(1'b0);
        do_read(d, oe);
        check_eq("busy_read_data", 32'(d), 32'h0);
        check_eq("busy_read_err", 32'(rd_err), 32'd1);
        wait_idle();
        do_read(d, oe);
        check_eq("post_busy_ch0", 32'(d), 32'h2000);
        do_read(d, oe);
        check_eq("post_busy_ch1", 32'(d), 32'h2001);
        check_eq("err_sticky", 32'(rd_err), 32'd1);

        // Config writes
        software_mode = 1'b1;
        do_write(16'h00A5);
        check_eq("cfg_sw", 32'(cfg_out), 32'hA5);
        software_mode = 1'b0;
        do_write(16'h003C);
        check_eq("cfg_hw_ignored", 32'(cfg_out), 32'hA5);

        // Reset mid-conversion
        load_samples(16'h3000);
        conv_all(1'b1);
        tick();
        tick();
        conv_all(1'b0);
        repeat (8) tick();
        check_eq("mid_conv_busy", 32'(busy), 32'd1);
        sreset = 1'b1;
        tick();
        sreset = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_cfg", 32'(cfg_out), 32'h0);
        do_read(d, oe);
        check_eq("abort_read_data", 32'(d), 32'h0);
        check_eq("abort_read_err", 32'(rd_err), 32'd0);
        check_eq("abort_busy_later", 32'(busy), 32'd0);

        // Standby blocks conversion
        standby_n = 1'b0;
        run_conv(n);
        for (int i = 0; i < 30; i++) begin
            if (busy) n++;
            tick();
        end
        check_eq("standby_no_busy", 32'(n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_responder.md
# adc_responder

Synthesizable ADC-side responder for the 8-channel parallel ADC interface that `driver` initiates on. It answers conversion starts with a BUSY pulse of programmable length, then serves the captured channel words on successive chip-select/read strobes, and latches software-mode configuration writes. It sits in place of the physical ADC for FPGA hardware-in-the-loop checks of `driver`, with channel samples supplied by an on-chip pattern source.

## Interface
- `CONV_CYCLES`, 25, `clk` cycles BUSY stays high per conversion (≥2)
- `NUM_CH`, 8, channels returned per frame
- `clk`  in  1  single system clock; all inputs sampled on its rising edge
- `sreset`  in  1  synchronous, active-high reset
- `chipselect_n`, `read_n`, `write_n`  in  1 each  bus strobes from `driver`
- `software_mode`, `standby_n`  in  1 each  mode pins from `driver`
- `conv_start_a`..`conv_start_d`  in  1 each  conversion start inputs
- `sample_in`  in  16×NUM_CH  channel words, ch0 in bits [15:0]
- `db_in`  in  16  data bus from `driver` during writes
- `busy`  out  1  conversion in progress
- `db_out`  out  16  data bus toward `driver`
- `db_oe`  out  1  bus drive enable (tristate resolved at top level)
- `cfg_out`  out  8  last configuration byte written
- `rd_err`  out  1  sticky: read attempted during BUSY or after frame exhausted

## Operation
- Edge detect on registered copies of `read_n`, `write_n`, and `start_all = &conv_start_*`.
- FSM states IDLE, CONVERTING, READY.
  - IDLE/READY: rising `start_all` with `standby_n`=1 → capture `sample_in` into shadow, load counter with CONV_CYCLES-1, go CONVERTING.
  - CONVERTING: decrement; at 0 copy shadow → result registers, clear channel pointer, go READY. `start_all` edges ignored.
  - `standby_n`=0 in any state → IDLE, busy low, results retained.
- Read: falling `read_n` while `chipselect_n`=0.
  - READY, ptr<NUM_CH: `db_out` ← result[ptr], ptr+1.
  - READY, ptr=NUM_CH: `db_out` ← 16'h0000, set `rd_err`, ptr holds (no wrap).
  - CONVERTING: `db_out` ← 16'h0000, set `rd_err`, ptr unchanged.
  - IDLE (never converted): `db_out` ← 16'h0000, no error.
- `db_oe` = registered (`chipselect_n`=0 && `read_n`=0).
- Write: rising `write_n` with `chipselect_n`=0 and `software_mode`=1 → `cfg_out` ← `db_in[7:0]`. Ignored when `software_mode`=0 or when `read_n`=0 on the same cycle.
- `rd_err` cleared only by reset or by the next accepted conversion start.

## Timing
- Reset: state IDLE, `busy`=0, `db_out`=0, `db_oe`=0, `cfg_out`=0, `rd_err`=0, ptr=0, results 0. Reset mid-conversion aborts it; shadow discarded.
- Start edge seen at edge N (start_all high at N, low at N-1) → `busy`=1 from N+1 through N+CONV_CYCLES, low at N+CONV_CYCLES+1; result registers valid at that same edge.
- `sample_in` captured at edge N.
- `read_n` falling seen at edge M → `db_out` valid from M+1, held until next accepted read; `db_oe` high from M+1 until one cycle after `read_n` or `chipselect_n` rises.
- Strobes must stay low/high ≥2 cycles; narrower pulses are not guaranteed to be detected.
- Start edge coincident with CONVERTING→READY transition edge: ignored (still CONVERTING at that edge).

## Structure
- `adc_if_pkg`: `adc_word_t` (logic [15:0]), `NUM_CH` default, state enum `adc_resp_state_e` {IDLE, CONVERTING, READY}, `ADC_IDLE_WORD` = 16'h0000.
- Sub-module `edge_detect` (registered input, rise/fall pulses), instanced for `read_n`, `write_n`, `start_all`.

## Test plan
- Reset then pulse all conv_start with `sample_in` ch k = 16'h1000+k, CONV_CYCLES=25 → `busy` high exactly 25 cycles starting one cycle after edge.
- After busy falls, 8 reads under `chipselect_n`=0 → `db_out` 16'h1000..16'h1007 in order, `rd_err`=0.
- 9th read → `db_out`=16'h0000, `rd_err`=1; next conversion start clears `rd_err`.
- Read during BUSY → 16'h0000, `rd_err`=1; post-conversion reads still start at ch0.
- `software_mode`=1, write 16'h00A5 → `cfg_out`=8'hA5; `software_mode`=0, write 16'h003C → `cfg_out` stays 8'hA5.
- Assert `sreset` at cycle 10 of conversion → `busy`=0 next cycle, reads return 16'h0000 with no error; `standby_n`=0 with start pulse → `busy` never rises.
